// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: rebuilds four parallel channels from a slot-tagged TDM stream.
// Optional strict slot ordering (0,1,2,3) is enabled by defining TDM_ORDER_CHECK_EN.
module tdm_demux_rx #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic [1:0]   din_sel,
   input  logic         din_valid,
   input  logic         frame_start,
   input  logic         out_ready,
   input  logic         err_clr,
   output logic [W-1:0] a_out,
   output logic [W-1:0] b_out,
   output logic [W-1:0] c_out,
   output logic [W-1:0] d_out,
   output logic         out_valid,
   output logic         seq_err,
   output logic         overrun
);

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_FULL    = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [3:0]   r_mask;
   logic [3:0]   w_mask_nxt;
   logic [3:0]   w_onehot;
   logic [W-1:0] r_stage [4];
   logic [W-1:0] w_stage_nxt [4];
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [W-1:0] r_c;
   logic [W-1:0] r_d;
   logic         r_out_valid;
   logic         r_seq_err;
   logic         r_overrun;
   logic         w_free;
   logic         w_xfer;
   logic         w_seq_set;
   logic         w_ovr_set;
   logic         w_accept;
`ifdef TDM_ORDER_CHECK_EN
   logic [1:0]   r_exp;
   logic [1:0]   w_exp_nxt;
`endif

   // Next-state logic: merge the incoming beat into staging and decide on transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_stage_nxt = r_stage;
      w_seq_set   = 1'b0;
      w_ovr_set   = 1'b0;
      w_xfer      = 1'b0;
      w_accept    = 1'b1;
      w_onehot    = 4'b0001 << din_sel;
      w_free      = !r_out_valid || out_ready;
`ifdef TDM_ORDER_CHECK_EN
      w_exp_nxt   = r_exp;
`endif
      unique case (r_state)
         S_COLLECT: begin
            if (din_valid) begin
`ifdef TDM_ORDER_CHECK_EN
               w_accept = frame_start ? (din_sel == 2'd0) : (din_sel == r_exp);
`endif
               if (w_accept) begin
                  w_stage_nxt[din_sel] = din;
                  if (frame_start) begin
                     w_mask_nxt = w_onehot;
                     w_seq_set  = |r_mask;
                  end else begin
                     w_mask_nxt = r_mask | w_onehot;
                     w_seq_set  = |(r_mask & w_onehot);
                  end
`ifdef TDM_ORDER_CHECK_EN
                  w_exp_nxt = din_sel + 2'd1;
`endif
               end else begin
                  w_seq_set  = 1'b1;
                  w_mask_nxt = 4'b0000;
`ifdef TDM_ORDER_CHECK_EN
                  w_exp_nxt  = 2'd0;
`endif
               end
            end
            if (w_mask_nxt == 4'b1111) begin
               if (w_free) begin
                  w_xfer = 1'b1;
               end else begin
                  w_state_nxt = S_FULL;
               end
            end
         end
         S_FULL: begin
            w_ovr_set = din_valid;
            w_xfer    = w_free;
         end
         default: begin
            w_state_nxt = S_COLLECT;
         end
      endcase
      if (w_xfer) begin
         w_mask_nxt  = 4'b0000;
         w_state_nxt = S_COLLECT;
`ifdef TDM_ORDER_CHECK_EN
         w_exp_nxt   = 2'd0;
`endif
      end
   end

   // Staging registers, slot mask and collection state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_COLLECT;
         r_mask  <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         for (int i = 0; i < 4; i++) begin
            r_stage[i] <= w_stage_nxt[i];
         end
      end
   end

`ifdef TDM_ORDER_CHECK_EN
   // Expected next slot for strict ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp <= 2'd0;
      end else begin
         r_exp <= w_exp_nxt;
      end
   end
`endif

   // Output frame register with valid/ready handshake; data holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_d         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_a         <= w_stage_nxt[0];
         r_b         <= w_stage_nxt[1];
         r_c         <= w_stage_nxt[2];
         r_d         <= w_stage_nxt[3];
         r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_err <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_seq_err <= w_seq_set || (r_seq_err && !err_clr);
         r_overrun <= w_ovr_set || (r_overrun && !err_clr);
      end
   end

   assign a_out     = r_a;
   assign b_out     = r_b;
   assign c_out     = r_c;
   assign d_out     = r_d;
   assign out_valid = r_out_valid;
   assign seq_err   = r_seq_err;
   assign overrun   = r_overrun;

endmodule
